// File: rtl/rect_up_if.sv
// ---------------------------------------------------------------------------
// rect_up_if -- link bundle between the rectifier serial line, the rect_up
// frame receiver and the downstream status logic.
//
// Signals
//   rect_rcv    serial line (asynchronous to clk), idle low
//   rect_data   last good 20-bit rectifier status word
//   rect_valid  one-cycle pulse: good frame received, rect_data updated
//   frame_err   one-cycle pulse: frame aborted or rejected
//
// Modports
//   master  the receiver: consumes the line, produces status and strobes
//   slave   the environment: drives the line, observes status and strobes
// ---------------------------------------------------------------------------
interface rect_up_if;
  logic        rect_rcv;
  logic [19:0] rect_data;
  logic        rect_valid;
  logic        frame_err;

  modport master (
    input  rect_rcv,
    output rect_data,
    output rect_valid,
    output frame_err
  );

  modport slave (
    output rect_rcv,
    input  rect_data,
    input  rect_valid,
    input  frame_err
  );
endinterface

// File: rtl/rect_up.sv
// ---------------------------------------------------------------------------
// rect_up -- far-end decoder of the 84-bit rectifier status frame.
//
// Receives seven 12-bit byte slots (start bit 1, eight inverted data bits LSB
// first, at least three idle-low bits), validates the frame
// 55, {0,D[19:16]}, D[15:8], D[7:0], D[15:8], D[7:0], AA and delivers the
// 20-bit status word D with a one-cycle valid or error strobe.
//
// Parameters
//   BIT_CYC  clk cycles per serial bit
//   GAP_TO   bit periods allowed from a byte's last data sample to the next
//            start edge before the frame is abandoned
//
// Ports
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  rect_up_if.master: rect_rcv in; rect_data, rect_valid, frame_err out
//
// Configuration
//   RECT_UP_DUP_CHECK_EN  when defined, the repeated bytes b4/b5 must match
//                         b2/b3; a mismatch rejects the frame after the b5
//                         guard sample. When undefined b4/b5 are framed only.
// ---------------------------------------------------------------------------
module rect_up #(
  parameter int unsigned BIT_CYC = 2223,
  parameter int unsigned GAP_TO  = 6
) (
  input  logic       clk,
  input  logic       rst,
  rect_up_if.master  bus
);

  localparam int unsigned GAP_MAX = GAP_TO * BIT_CYC;
  localparam int unsigned GW      = $clog2(GAP_MAX + 1);

  localparam logic [15:0]   HALF_CNT  = 16'(BIT_CYC / 2);
  localparam logic [15:0]   LAST_CNT  = 16'(BIT_CYC - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_MAX);

  typedef enum logic [1:0] {IDLE, START, DATA, GUARD} state_e;

  // Registered state
  logic          sync1_q, sync2_q, prev_q;
  state_e        state_q,     state_d;
  logic [15:0]   bit_cnt_q,   bit_cnt_d;
  logic [2:0]    data_cnt_q,  data_cnt_d;
  logic [7:0]    shift_q,     shift_d;
  logic [2:0]    byte_idx_q,  byte_idx_d;
  logic [GW-1:0] gap_q,       gap_d;
  logic [3:0]    nib_q,       nib_d;
  logic [7:0]    b2_q,        b2_d;
  logic [7:0]    b3_q,        b3_d;
  logic [19:0]   rect_data_q, rect_data_d;
  logic          rect_valid_q, rect_valid_d;
  logic          frame_err_q,  frame_err_d;
`ifdef RECT_UP_DUP_CHECK_EN
  logic          dup_bad_q,   dup_bad_d;
`endif

  // Events derived from the current state
  logic start_edge, bit_tick, data_smp, guard_smp, last_data;
  logic timeout, byte_ok, accept, abort, good;

  // A start edge is the synchronised line rising from idle low.
  assign start_edge = sync2_q & ~prev_q;

  // START samples mid start bit; DATA/GUARD sample one full bit later each.
  assign bit_tick  = (state_q == START) ? (bit_cnt_q == HALF_CNT)
                                        : (bit_cnt_q == LAST_CNT);
  assign data_smp  = (state_q == DATA)  && bit_tick;
  assign guard_smp = (state_q == GUARD) && bit_tick;
  assign last_data = data_smp && (data_cnt_q == 3'd7);

  // Between bytes of a frame the gap counter bounds the wait for the next
  // start; a start edge landing on the limit cycle still wins.
  assign timeout = (state_q == IDLE) && (byte_idx_q != 3'd0) &&
                   (gap_q == GAP_LIMIT) && !start_edge;

  // Content check of the byte just shifted in, by its slot in the frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned -- that is what keeps the tool from inferring a latch.
    byte_ok = 1'b1;
    case (byte_idx_q)
      3'd0:    byte_ok = (shift_q == 8'h55);
      3'd1:    byte_ok = (shift_q[7:4] == 4'h0);
`ifdef RECT_UP_DUP_CHECK_EN
      // A bad b4 is remembered and only reported once b5 is complete.
      3'd5:    byte_ok = !dup_bad_q && (shift_q == b3_q);
`endif
      3'd6:    byte_ok = (shift_q == 8'hAA);
      default: byte_ok = 1'b1;
    endcase
  end

  // Guard bit must be low (idle) for the byte to be accepted.
  assign accept = guard_smp && !sync2_q && byte_ok;
  assign abort  = timeout || (guard_smp && !accept);
  assign good   = accept && (byte_idx_q == 3'd6);

  // State register (plus datapath flops)
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      data_cnt_q   <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      gap_q        <= '0;
      nib_q        <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
      rect_data_q  <= '0;
      rect_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RECT_UP_DUP_CHECK_EN
      dup_bad_q    <= 1'b0;
`endif
    end else begin
      sync1_q      <= bus.rect_rcv;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      data_cnt_q   <= data_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      gap_q        <= gap_d;
      nib_q        <= nib_d;
      b2_q         <= b2_d;
      b3_q         <= b3_d;
      rect_data_q  <= rect_data_d;
      rect_valid_q <= rect_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef RECT_UP_DUP_CHECK_EN
      dup_bad_q    <= dup_bad_d;
`endif
    end
  end

  // Next-state logic: edges seen outside IDLE are ignored, sampling is
  // purely time based once a start edge has been taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = START;
      START:   if (bit_tick)   state_d = sync2_q ? DATA : IDLE;
      DATA:    if (last_data)  state_d = GUARD;
      GUARD:   if (bit_tick)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    data_cnt_d   = data_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    gap_d        = gap_q;
    nib_d        = nib_q;
    b2_d         = b2_q;
    b3_d         = b3_q;
    rect_data_d  = rect_data_q;
    rect_valid_d = good;
    frame_err_d  = abort;
`ifdef RECT_UP_DUP_CHECK_EN
    dup_bad_d    = dup_bad_q;
`endif

    // Bit timer: runs only while a byte is in flight, cleared at each sample.
    if (state_q == IDLE) begin
      if (start_edge) bit_cnt_d = '0;
    end else if (bit_tick) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + 16'd1;
    end

    if ((state_q == START) && bit_tick) data_cnt_d = '0;
    if (data_smp) begin
      data_cnt_d = data_cnt_q + 3'd1;
      // Data bits travel inverted, LSB first.
      shift_d    = {~sync2_q, shift_q[7:1]};
    end

    // Gap counter restarts at each byte's last data sample and saturates.
    if (last_data)              gap_d = '0;
    else if (gap_q != GAP_LIMIT) gap_d = gap_q + GW'(1);

    if (accept) begin
      case (byte_idx_q)
        3'd1:    nib_d = shift_q[3:0];
        3'd2:    b2_d  = shift_q;
        3'd3:    b3_d  = shift_q;
`ifdef RECT_UP_DUP_CHECK_EN
        3'd4:    dup_bad_d = (shift_q != b2_q);
`endif
        default: ;
      endcase
    end

    if (abort || good) byte_idx_d = '0;
    else if (accept)   byte_idx_d = byte_idx_q + 3'd1;

    // b1..b3 are already held in their registers when b6 completes.
    if (good) rect_data_d = {nib_q, b2_q, b3_q};
  end

  assign bus.rect_data  = rect_data_q;
  assign bus.rect_valid = rect_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_rect_up.sv
// ---------------------------------------------------------------------------
// tb_rect_up -- randomized, scoreboard-checked bench for rect_up.
// Frames are described as seven byte values plus an optional line fault
// (high guard bit, early end of transmission). A frame-level reference model
// derives the expected strobe and rect_data and pushes it to a queue; an
// independent monitor pops and compares on every DUT strobe.
// ---------------------------------------------------------------------------
module tb_rect_up;
  localparam int BIT_CYC = 24;
  localparam int GAP_TO  = 6;
  localparam int CLK_T   = 10;
  localparam int BIT_T   = BIT_CYC * CLK_T;

  typedef logic [7:0] frame_t [7];
  typedef struct packed {
    logic        is_err;
    logic [19:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  rect_up_if bus ();

  rect_up #(.BIT_CYC(BIT_CYC), .GAP_TO(GAP_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #(CLK_T / 2) clk = ~clk;

  exp_t        sb[$];
  logic [19:0] last_good;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          bit_t    = BIT_T;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.rect_valid || bus.frame_err)) begin
      exp_t e;
      check("strobe_exclusive", {31'd0, bus.rect_valid & bus.frame_err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, bus.rect_valid, bus.frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
        check("rect_valid", {31'd0, bus.rect_valid}, {31'd0, ~e.is_err});
        check("rect_data", {12'd0, bus.rect_data}, {12'd0, e.data});
      end
    end
  end

  function automatic frame_t mk_frame(input logic [19:0] d);
    frame_t f;
    f[0] = 8'h55; f[1] = {4'h0, d[19:16]}; f[2] = d[15:8]; f[3] = d[7:0];
    f[4] = d[15:8]; f[5] = d[7:0]; f[6] = 8'hAA;
    return f;
  endfunction

  // Frame-level reference: walk the bytes in transmission order and report
  // the first reason to reject, and the last byte the receiver will see.
  function automatic exp_t model(input frame_t f, input int guard_bad, input int n_sent,
                                 output int last_idx);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    for (int i = 0; i < 7; i++) begin
      last_idx = i;
      if (i >= n_sent) begin last_idx = i - 1; return e; end
      if (i == guard_bad) return e;
      if (i == 0 && f[0] != 8'h55) return e;
      if (i == 1 && f[1][7:4] != 4'h0) return e;
`ifdef RECT_UP_DUP_CHECK_EN
      if (i == 5 && (f[4] != f[2] || f[5] != f[3])) return e;
`endif
      if (i == 6 && f[6] != 8'hAA) return e;
    end
    e.is_err = 1'b0;
    e.data   = {f[1][3:0], f[2], f[3]};
    return e;
  endfunction

  task automatic send_bit(input logic v);
    bus.rect_rcv = v;
    #(bit_t);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit guard_one, input int stop_bits);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(~b[i]);
    if (guard_one) send_bit(1'b1);
    for (int i = 0; i < stop_bits; i++) send_bit(1'b0);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 30 * BIT_CYC && sb.size() != 0; c++) @(posedge clk);
    check("strobe_arrived", sb.size(), 32'd0);
    sb.delete();
  endtask

  // guard_bad: slot whose guard bit is sent high (-1 none);
  // n_sent: slots transmitted before the line falls silent.
  task automatic run_frame(input frame_t f, input int guard_bad, input int n_sent);
    exp_t e;
    int   last;
    e = model(f, guard_bad, n_sent, last);
    sb.push_back(e);
    if (!e.is_err) last_good = e.data;
    for (int i = 0; i <= last; i++) begin
      if (i == last && n_sent < 7) send_byte(f[i], 1'b0, 7);
      else if (i == last)          send_byte(f[i], i == guard_bad, 4);
      else                         send_byte(f[i], i == guard_bad, 3 + int'($urandom_range(1)));
    end
    wait_drain();
  endtask

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    logic [19:0] d;
    int kind;

    bus.rect_rcv = 1'b0;
    last_good    = '0;
    rst          = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data",  {12'd0, bus.rect_data}, 32'd0);
    check("reset_valid", {31'd0, bus.rect_valid}, 32'd0);
    check("reset_err",   {31'd0, bus.frame_err}, 32'd0);
    #(2 * BIT_T);

    // Reference frame
    run_frame(mk_frame(20'hA5C3F), -1, 7);
    // Bad trailer: error, data held
    f = mk_frame(20'hA5C3F); f[6] = 8'hAB;
    run_frame(f, -1, 7);
    // Duplicate mismatch: rejected only when the check is built in
    f = mk_frame(20'hA5C3F); f[4] = 8'h5D;
    run_frame(f, -1, 7);
    // Line silent after b3, then a good frame
    run_frame(mk_frame(20'hA5C3F), -1, 4);
    run_frame(mk_frame(20'h00001), -1, 7);

    // Short high glitch on the idle line: no strobe, next frame decodes
    bus.rect_rcv = 1'b1;
    #(BIT_T / 4);
    bus.rect_rcv = 1'b0;
    #(4 * BIT_T);
    check("glitch_quiet", sb.size(), 32'd0);
    run_frame(mk_frame(20'h3C0F5), -1, 7);

    // Reset in the middle of b2
    f = mk_frame(20'h12345);
    send_byte(f[0], 1'b0, 3);
    send_byte(f[1], 1'b0, 3);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_bit(~f[2][i]);
    bus.rect_rcv = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("midreset_data", {12'd0, bus.rect_data}, 32'd0);
    last_good = '0;
    #(10 * BIT_T);
    check("midreset_quiet", sb.size(), 32'd0);
    run_frame(mk_frame(20'h6789A), -1, 7);

    // Bit period skewed by about +/-2%
    bit_t = BIT_T + BIT_T / 50;
    run_frame(mk_frame(20'hF0E1D), -1, 7);
    bit_t = BIT_T - BIT_T / 50;
    run_frame(mk_frame(20'h0BEEF), -1, 7);
    bit_t = BIT_T;

    // Randomized frames with one optional fault each
    for (int n = 0; n < 12; n++) begin
      d    = 20'($urandom);
      f    = mk_frame(d);
      kind = int'($urandom_range(7));
      case (kind)
        1: f[0] = 8'h55 ^ 8'($urandom_range(255, 1));
        2: f[1][7:4] = 4'($urandom_range(15, 1));
        3: f[6] = 8'hAA ^ 8'($urandom_range(255, 1));
        6: f[4 + int'($urandom_range(1))] ^= 8'($urandom_range(255, 1));
        default: ;
      endcase
      if (kind == 4)      run_frame(f, int'($urandom_range(6)), 7);
      else if (kind == 5) run_frame(f, -1, int'($urandom_range(6, 1)));
      else                run_frame(f, -1, 7);
    end

    #(4 * BIT_T);
    check("final_queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
